mul_issue_ctrl: RTL

- Front-end and result stage for the radix-4 Booth multiplier `mul`.
- Accepts decoded RISC-V M-extension multiply ops (MUL/MULH/MULHSU/MULHU) over a valid/ready handshake.
- Drives the multiplier's request port and captures its 64-bit product the following cycle.
- Selects the architectural 32-bit word and buffers results in an in-order output FIFO with backpressure toward writeback.

---
 rtl/mul_pkg.sv | 29 ++
 rtl/mul_issue_ctrl_if.sv | 37 +++
 rtl/mul_out_fifo.sv | 46 ++++
 rtl/mul_issue_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types for the multiply issue/result stage: op encodings, operand
// signedness decode and the buffered result entry.
package mul_pkg;

    typedef logic [1:0] mul_op_t;

    localparam mul_op_t OP_MUL    = 2'b00;
    localparam mul_op_t OP_MULH   = 2'b01;
    localparam mul_op_t OP_MULHSU = 2'b10;
    localparam mul_op_t OP_MULHU  = 2'b11;

    // Widest tag a result entry can carry; narrower tags are zero-extended.
    localparam int TAG_MAX_W = 16;

    typedef struct packed {
        logic [31:0]          data;
        logic [TAG_MAX_W-1:0] tag;
    } mul_res_t;

    // Returns {in_1_signed, in_2_signed}.
    function automatic logic [1:0] op_signs(input mul_op_t op);
        case (op)
            OP_MUL, OP_MULH: op_signs = 2'b11;
            OP_MULHSU:       op_signs = 2'b10;
            default:         op_signs = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Bundle of the op handshake, multiplier request/response and result handshake.
// master = op producer / result consumer / multiplier side; slave = mul_issue_ctrl.
interface mul_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;

    logic             mul_req_valid;
    logic             mul_req_in_1_signed;
    logic             mul_req_in_2_signed;
    logic [31:0]      mul_req_in_1;
    logic [31:0]      mul_req_in_2;
    logic [63:0]      mul_resp_result;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, mul_resp_result, out_ready,
        input  in_ready, mul_req_valid, mul_req_in_1_signed, mul_req_in_2_signed,
               mul_req_in_1, mul_req_in_2, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, mul_resp_result, out_ready,
        output in_ready, mul_req_valid, mul_req_in_1_signed, mul_req_in_2_signed,
               mul_req_in_1, mul_req_in_2, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/mul_out_fifo.sv
// Generic in-order synchronous FIFO; DEPTH must be a power of two >= 2.
// Storage is zeroed on reset so the head reads 0 afterwards.
module mul_out_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [W-1:0]          i_data,
    input  logic                  i_pop,
    output logic [W-1:0]          o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (i_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue front-end and result stage for the radix-4 Booth multiplier.
// Optional MUL_BYPASS_EN: forward the captured word straight out when the FIFO is empty.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 5
) (
    input logic             clk,
    input logic             reset,
    input logic             flush,
    mul_issue_ctrl_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             r_pend;
    mul_op_t          r_pend_op;
    logic [TAG_W-1:0] r_pend_tag;

    logic             w_acc;
    logic             w_push;
    logic             w_fifo_pop;
    logic             w_out_pop;
    logic [1:0]       w_signs;
    logic [CW-1:0]    w_count;
    logic [CW:0]      w_occ;
    mul_res_t         w_cap;
    mul_res_t         w_head;
    logic             w_unused_tag;

    assign w_acc                   = bus.in_valid & bus.in_ready;
    assign w_signs                 = op_signs(bus.in_op);
    assign bus.mul_req_valid       = w_acc;
    assign bus.mul_req_in_1_signed = w_signs[1];
    assign bus.mul_req_in_2_signed = w_signs[0];
    assign bus.mul_req_in_1        = bus.in_a;
    assign bus.mul_req_in_2        = bus.in_b;

    // Product is valid only in the cycle after the request, i.e. while r_pend is set.
    assign w_cap.data = (r_pend_op == OP_MUL) ? bus.mul_resp_result[31:0]
                                              : bus.mul_resp_result[63:32];
    assign w_cap.tag  = TAG_MAX_W'(r_pend_tag);

`ifdef MUL_BYPASS_EN
    logic w_bypass;
    assign w_bypass      = r_pend & (w_count == '0);
    assign bus.out_valid = w_bypass | (w_count != '0);
    assign bus.out_data  = w_bypass ? w_cap.data : w_head.data;
    assign bus.out_tag   = w_bypass ? r_pend_tag : w_head.tag[TAG_W-1:0];
    assign w_push        = r_pend & ~flush & ~(w_bypass & bus.out_ready);
    assign w_fifo_pop    = (w_count != '0) & bus.out_ready;
`else
    assign bus.out_valid = (w_count != '0);
    assign bus.out_data  = w_head.data;
    assign bus.out_tag   = w_head.tag[TAG_W-1:0];
    assign w_push        = r_pend & ~flush;
    assign w_fifo_pop    = bus.out_valid & bus.out_ready;
`endif

    // Reserve a slot for the in-flight product so capture can never stall.
    assign w_out_pop    = bus.out_valid & bus.out_ready;
    assign w_occ        = {1'b0, w_count} + (CW+1)'(r_pend) - (CW+1)'(w_out_pop);
    assign bus.in_ready = ~reset & ~flush & (w_occ < (CW+1)'(DEPTH));
    assign w_unused_tag = |w_head.tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend     <= 1'b0;
            r_pend_op  <= OP_MUL;
            r_pend_tag <= '0;
        end else begin
            r_pend <= w_acc;
            if (w_acc) begin
                r_pend_op  <= bus.in_op;
                r_pend_tag <= bus.in_tag;
            end
        end
    end

    mul_out_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(mul_res_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (flush),
        .i_push  (w_push),
        .i_data  (w_cap),
        .i_pop   (w_fifo_pop),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule
